brick_game_sequencer: RTL and testbench

Game-flow controller for the brick-smashing ball-and-paddle game. Sequences the playfield datapath through brick-array wipe, attract, serve, play, ball-lost, level-clear and game-over phases. Drives the ball-hold, brick-clear write port and lives-decrement strobe consumed by the top level and `player_stats`. Runs on the pixel clock and uses vsync as its frame tick.

---
 rtl/brick_game_sequencer.sv | 169 ++++++++++++++++
 tb/tb_brick_game_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_game_sequencer.sv
// Game-flow controller for the brick game: wipes the brick array, then sequences
// serve, play, ball-lost, level-clear and game-over phases, using vsync as the frame tick.
module brick_game_sequencer #(
  parameter int NUM_BRICKS   = 128,
  parameter int SERVE_FRAMES = 60,
  parameter int LOST_FRAMES  = 60,
  parameter int CLEAR_FRAMES = 30,
  parameter int LOST_Y       = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic       brick_hit,
  input  logic [8:0] ball_y,
  input  logic [3:0] lives,
  output logic       ball_hold,
  output logic       clear_we,
  output logic [6:0] clear_addr,
  output logic       declives,
  output logic       game_over,
  output logic [3:0] level,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    WIPE     = 3'd0,
    IDLE     = 3'd1,
    SERVE    = 3'd2,
    PLAY     = 3'd3,
    LOST     = 3'd4,
    LEVELCLR = 3'd5,
    GAMEOVER = 3'd6
  } state_t;

  state_t     fsm;
  logic       vsync_q;
  logic       start_q;
  logic       wipe_to_serve;
  logic [7:0] bricks_left;
  logic [7:0] frame_cnt;
  logic [8:0] frame_next;
  logic       frame_tick;
  logic       start_edge;
  logic       serve_done;
  logic       lost_done;
  logic       clear_done;
  logic       last_brick;
  logic       ball_lost;

  assign frame_tick = vsync & ~vsync_q;
  assign start_edge = start & ~start_q;

  // A phase of N frames ends on the tick that would make the count reach N; N=0 ends on the first tick.
  assign frame_next = {1'b0, frame_cnt} + 9'd1;
  assign serve_done = frame_tick && (frame_next >= 9'(SERVE_FRAMES));
  assign lost_done  = frame_tick && (frame_next >= 9'(LOST_FRAMES));
  assign clear_done = frame_tick && (frame_next >= 9'(CLEAR_FRAMES));

  assign last_brick = (bricks_left == 8'd0) || (brick_hit && (bricks_left == 8'd1));
  assign ball_lost  = frame_tick && (ball_y >= 9'(LOST_Y));
  assign state      = fsm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm           <= WIPE;
      vsync_q       <= 1'b0;
      start_q       <= 1'b0;
      wipe_to_serve <= 1'b0;
      bricks_left   <= 8'd0;
      frame_cnt     <= 8'd0;
      clear_we      <= 1'b1;
      clear_addr    <= 7'd0;
      ball_hold     <= 1'b1;
      declives      <= 1'b0;
      game_over     <= 1'b0;
      level         <= 4'd0;
    end else begin
      vsync_q  <= vsync;
      start_q  <= start;
      declives <= 1'b0;
      if (frame_tick) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      case (fsm)
        WIPE: begin
          if (clear_addr == 7'(NUM_BRICKS - 1)) begin
            clear_we    <= 1'b0;
            clear_addr  <= 7'd0;
            bricks_left <= 8'(NUM_BRICKS);
            frame_cnt   <= 8'd0;
            fsm         <= wipe_to_serve ? SERVE : IDLE;
          end else begin
            clear_addr <= clear_addr + 7'd1;
          end
        end
        IDLE: begin
          if (start_edge) begin
            fsm       <= SERVE;
            frame_cnt <= 8'd0;
          end
        end
        SERVE: begin
          if (serve_done) begin
            fsm       <= PLAY;
            ball_hold <= 1'b0;
            frame_cnt <= 8'd0;
          end
        end
        PLAY: begin
          if (brick_hit && (bricks_left != 8'd0)) begin
            bricks_left <= bricks_left - 8'd1;
          end
          // Clearing the last brick takes priority over losing the ball in the same cycle.
          if (last_brick) begin
            fsm       <= LEVELCLR;
            ball_hold <= 1'b1;
            frame_cnt <= 8'd0;
          end else if (ball_lost) begin
            fsm       <= LOST;
            ball_hold <= 1'b1;
            declives  <= 1'b1;
            frame_cnt <= 8'd0;
          end
        end
        LOST: begin
          if (lost_done) begin
            frame_cnt <= 8'd0;
            if (lives == 4'd0) begin
              fsm       <= GAMEOVER;
              game_over <= 1'b1;
            end else begin
              fsm <= SERVE;
            end
          end
        end
        LEVELCLR: begin
          if (clear_done) begin
            level         <= level + 4'd1;
            fsm           <= WIPE;
            clear_we      <= 1'b1;
            clear_addr    <= 7'd0;
            wipe_to_serve <= 1'b1;
            frame_cnt     <= 8'd0;
          end
        end
        GAMEOVER: begin
          if (start_edge) begin
            level         <= 4'd0;
            fsm           <= WIPE;
            game_over     <= 1'b0;
            clear_we      <= 1'b1;
            clear_addr    <= 7'd0;
            wipe_to_serve <= 1'b0;
            frame_cnt     <= 8'd0;
          end
        end
        default: begin
          fsm        <= WIPE;
          clear_we   <= 1'b1;
          clear_addr <= 7'd0;
          ball_hold  <= 1'b1;
          game_over  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brick_game_sequencer.sv
// Self-checking bench for brick_game_sequencer: walks the game through every phase with
// randomized frame timing, ball positions and hit spacing, checked against a rule-level model.
module tb_brick_game_sequencer;

  localparam int NB = 128;
  localparam int SF = 60;
  localparam int LF = 60;
  localparam int CF = 30;
  localparam int LY = 240;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic       start;
  logic       brick_hit;
  logic [8:0] ball_y;
  logic [3:0] lives;
  logic       ball_hold;
  logic       clear_we;
  logic [6:0] clear_addr;
  logic       declives;
  logic       game_over;
  logic [3:0] level;
  logic [2:0] state;

  int passed = 0;
  int total = 0;
  int declives_seen = 0;
  int bricks_model = 0;
  int exp_level = 0;

  brick_game_sequencer dut (
    .clk(clk), .reset(reset), .vsync(vsync), .start(start), .brick_hit(brick_hit),
    .ball_y(ball_y), .lives(lives), .ball_hold(ball_hold), .clear_we(clear_we),
    .clear_addr(clear_addr), .declives(declives), .game_over(game_over),
    .level(level), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (declives === 1'b1) declives_seen++;

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: time limit reached, state=%0d", state);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
  endtask

  // Outside PLAY, noise adds stray brick hits and unrestricted ball positions, which must be ignored.
  task automatic frames(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      if (noise) begin
        ball_y = 9'($urandom_range(0, 511));
        brick_hit = 1'b1;
        step();
        brick_hit = 1'b0;
      end else begin
        ball_y = 9'($urandom_range(0, LY - 1));
      end
      vsync = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      vsync = 1'b0;
      repeat ($urandom_range(1, 3)) step();
    end
  endtask

  task automatic run_wipe(output int n, output int errs);
    int cnt = 0;
    int bad = 0;
    while (clear_we === 1'b1 && cnt < 300) begin
      if (clear_addr !== 7'(cnt)) bad++;
      cnt++;
      step();
    end
    n = cnt;
    errs = bad;
  endtask

  task automatic play_hits(output int bad);
    int b = 0;
    int hits = 0;
    while (bricks_model > 1) begin
      brick_hit = 1'b1;
      step();
      brick_hit = 1'b0;
      bricks_model--;
      hits++;
      if (state !== 3'd3) b++;
      repeat ($urandom_range(0, 2)) step();
      if (hits % 16 == 0) begin
        ball_y = 9'($urandom_range(0, LY - 1));
        tick_once();
        step();
        if (state !== 3'd3) b++;
      end
    end
    bad = b;
  endtask

  task automatic to_play();
    frames(SF - 1, 1'b1);
    total++;
    if (state !== 3'd2 || ball_hold !== 1'b1)
      $display("[TB] FAIL serve_hold: state=%0d hold=%0b, expected state=2 hold=1", state, ball_hold);
    else passed++;
    frames(1, 1'b1);
    total++;
    if (state !== 3'd3 || ball_hold !== 1'b0)
      $display("[TB] FAIL serve_release: state=%0d hold=%0b, expected state=3 hold=0", state, ball_hold);
    else passed++;
  endtask

  task automatic test_reset();
    int n, errs;
    reset = 1'b1;
    step();
    step();
    total++;
    if (state !== 3'd0 || clear_we !== 1'b1 || clear_addr !== 7'd0 || ball_hold !== 1'b1 ||
        declives !== 1'b0 || game_over !== 1'b0 || level !== 4'd0)
      $display("[TB] FAIL reset_values: state=%0d we=%0b addr=%0d hold=%0b dec=%0b go=%0b lvl=%0d",
               state, clear_we, clear_addr, ball_hold, declives, game_over, level);
    else passed++;
    reset = 1'b0;
    run_wipe(n, errs);
    total++;
    if (n != NB || errs != 0)
      $display("[TB] FAIL reset_wipe: %0d cycles with %0d addr errors, expected %0d cycles, 0 errors", n, errs, NB);
    else passed++;
    total++;
    if (state !== 3'd1 || ball_hold !== 1'b1 || declives_seen != 0)
      $display("[TB] FAIL reset_idle: state=%0d hold=%0b declives=%0d, expected 1/1/0", state, ball_hold, declives_seen);
    else passed++;
    bricks_model = NB;
  endtask

  task automatic test_serve();
    start = 1'b1;
    step();
    total++;
    if (state !== 3'd2) $display("[TB] FAIL idle_start: state=%0d, expected 2", state);
    else passed++;
    to_play();
    repeat (5) step();
    total++;
    if (state !== 3'd3) $display("[TB] FAIL start_held: state=%0d, expected 3", state);
    else passed++;
    start = 1'b0;
  endtask

  task automatic test_level_clear();
    int bad, n, errs;
    play_hits(bad);
    total++;
    if (bad != 0) $display("[TB] FAIL play_hits: %0d samples left PLAY early, expected 0", bad);
    else passed++;
    brick_hit = 1'b1;
    step();
    brick_hit = 1'b0;
    bricks_model = 0;
    total++;
    if (state !== 3'd5 || ball_hold !== 1'b1)
      $display("[TB] FAIL last_brick: state=%0d hold=%0b, expected 5/1", state, ball_hold);
    else passed++;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    frames(CF - 1, 1'b1);
    total++;
    if (state !== 3'd5) $display("[TB] FAIL levelclr_hold: state=%0d, expected 5", state);
    else passed++;
    tick_once();
    exp_level = (exp_level + 1) % 16;
    total++;
    if (state !== 3'd0 || level !== 4'(exp_level) || clear_we !== 1'b1 || clear_addr !== 7'd0)
      $display("[TB] FAIL levelclr_exit: state=%0d level=%0d we=%0b addr=%0d, expected 0/%0d/1/0",
               state, level, clear_we, clear_addr, exp_level);
    else passed++;
    run_wipe(n, errs);
    total++;
    if (n != NB || errs != 0)
      $display("[TB] FAIL level_wipe: %0d cycles with %0d addr errors, expected %0d/0", n, errs, NB);
    else passed++;
    bricks_model = NB;
    total++;
    if (state !== 3'd2 || ball_hold !== 1'b1)
      $display("[TB] FAIL level_wipe_next: state=%0d hold=%0b, expected 2/1", state, ball_hold);
    else passed++;
  endtask

  task automatic test_ball_lost(input int lv);
    int d0;
    int exp_state;
    lives = 4'(lv);
    frames(3, 1'b0);
    total++;
    if (state !== 3'd3 || ball_hold !== 1'b0)
      $display("[TB] FAIL ball_safe: state=%0d hold=%0b, expected 3/0", state, ball_hold);
    else passed++;
    d0 = declives_seen;
    ball_y = 9'($urandom_range(LY, 511));
    tick_once();
    total++;
    if (state !== 3'd4 || declives !== 1'b1 || ball_hold !== 1'b1)
      $display("[TB] FAIL lost_entry: state=%0d dec=%0b hold=%0b, expected 4/1/1", state, declives, ball_hold);
    else passed++;
    step();
    total++;
    if (declives !== 1'b0) $display("[TB] FAIL declives_width: declives=%0b one cycle later, expected 0", declives);
    else passed++;
    frames(LF - 1, 1'b1);
    total++;
    if (state !== 3'd4) $display("[TB] FAIL lost_hold: state=%0d, expected 4", state);
    else passed++;
    tick_once();
    exp_state = (lv == 0) ? 6 : 2;
    total++;
    if (state !== 3'(exp_state) || game_over !== ((lv == 0) ? 1'b1 : 1'b0))
      $display("[TB] FAIL lost_exit: lives=%0d state=%0d go=%0b, expected %0d/%0b",
               lv, state, game_over, exp_state, (lv == 0));
    else passed++;
    step();
    total++;
    if (declives_seen - d0 != 1)
      $display("[TB] FAIL declives_count: %0d pulses, expected 1", declives_seen - d0);
    else passed++;
  endtask

  task automatic test_game_over();
    int n, errs;
    start = 1'b0;
    repeat (3) step();
    total++;
    if (state !== 3'd6 || game_over !== 1'b1)
      $display("[TB] FAIL gameover_hold: state=%0d go=%0b, expected 6/1", state, game_over);
    else passed++;
    start = 1'b1;
    step();
    exp_level = 0;
    total++;
    if (state !== 3'd0 || level !== 4'd0 || game_over !== 1'b0 || clear_we !== 1'b1)
      $display("[TB] FAIL gameover_restart: state=%0d level=%0d go=%0b we=%0b, expected 0/0/0/1",
               state, level, game_over, clear_we);
    else passed++;
    run_wipe(n, errs);
    bricks_model = NB;
    total++;
    if (n != NB || errs != 0)
      $display("[TB] FAIL gameover_wipe: %0d cycles with %0d addr errors, expected %0d/0", n, errs, NB);
    else passed++;
    repeat (4) step();
    total++;
    if (state !== 3'd1 || level !== 4'd0)
      $display("[TB] FAIL gameover_idle: state=%0d level=%0d, expected 1/0", state, level);
    else passed++;
    start = 1'b0;
  endtask

  task automatic test_restart();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (state !== 3'd2) $display("[TB] FAIL restart_serve: state=%0d, expected 2", state);
    else passed++;
    to_play();
  endtask

  task automatic test_coincident();
    int bad, d0;
    play_hits(bad);
    total++;
    if (bad != 0) $display("[TB] FAIL coinc_hits: %0d samples left PLAY early, expected 0", bad);
    else passed++;
    d0 = declives_seen;
    ball_y = 9'd250;
    brick_hit = 1'b1;
    vsync = 1'b1;
    step();
    brick_hit = 1'b0;
    vsync = 1'b0;
    bricks_model = 0;
    total++;
    if (state !== 3'd5 || declives !== 1'b0)
      $display("[TB] FAIL coinc_state: state=%0d dec=%0b, expected 5/0", state, declives);
    else passed++;
    step();
    step();
    total++;
    if (declives_seen != d0)
      $display("[TB] FAIL coinc_declives: %0d pulses, expected 0", declives_seen - d0);
    else passed++;
    frames(CF - 1, 1'b1);
    tick_once();
    exp_level = (exp_level + 1) % 16;
    total++;
    if (state !== 3'd0 || level !== 4'(exp_level))
      $display("[TB] FAIL coinc_exit: state=%0d level=%0d, expected 0/%0d", state, level, exp_level);
    else passed++;
    step();
  endtask

  task automatic test_reset_mid_wipe();
    int n, errs;
    for (int k = 0; k < 200 && clear_addr !== 7'd60; k++) step();
    total++;
    if (clear_addr !== 7'd60 || clear_we !== 1'b1)
      $display("[TB] FAIL wipe_reach60: addr=%0d we=%0b, expected 60/1", clear_addr, clear_we);
    else passed++;
    reset = 1'b1;
    #1;
    exp_level = 0;
    total++;
    if (clear_addr !== 7'd0 || state !== 3'd0 || level !== 4'd0 || clear_we !== 1'b1)
      $display("[TB] FAIL midwipe_reset: addr=%0d state=%0d level=%0d we=%0b, expected 0/0/0/1",
               clear_addr, state, level, clear_we);
    else passed++;
    step();
    reset = 1'b0;
    run_wipe(n, errs);
    total++;
    if (n != NB || errs != 0)
      $display("[TB] FAIL midwipe_rewipe: %0d cycles with %0d addr errors, expected %0d/0", n, errs, NB);
    else passed++;
    total++;
    if (state !== 3'd1 || level !== 4'd0)
      $display("[TB] FAIL midwipe_idle: state=%0d level=%0d, expected 1/0", state, level);
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    vsync = 1'b0;
    start = 1'b0;
    brick_hit = 1'b0;
    ball_y = 9'd0;
    lives = 4'd3;
    test_reset();
    test_serve();
    test_level_clear();
    to_play();
    test_ball_lost($urandom_range(1, 15));
    to_play();
    test_ball_lost(0);
    test_game_over();
    test_restart();
    test_coincident();
    test_reset_mid_wipe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
